mips_cpu_instr_encoder: RTL

Sequential instruction encoder and program loader for the MIPS CPU test environment, the inverse of the control decoder. It accepts one symbolic instruction per handshake: a mnemonic ID plus rs, rt, rd, shamt and immediate fields. It packs these into the 32-bit MIPS I word and writes it over the Avalon-style memory port at consecutive word addresses from a base address. It sits between the bench or boot logic and instruction memory, so programs can be generated in-sim and round-tripped through the CPU's decoder.

---
 rtl/mips_cpu_instr_encoder_pkg.sv | 63 ++++++
 rtl/mips_cpu_instr_encoder_pack.sv | 86 ++++++++
 rtl/mips_cpu_instr_encoder.sv | 99 +++++++++
 3 files changed

// File: rtl/mips_cpu_instr_encoder_pkg.sv
// Shared MIPS I encodings: opcodes, SPECIAL functs, REGIMM rt codes,
// the symbolic mnemonic IDs and the encoder FSM states.
package mips_cpu_instr_encoder_pkg;

  typedef enum logic [5:0] {
    OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02, OP_JAL   = 6'h03,
    OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ  = 6'h06, OP_BGTZ  = 6'h07,
    OP_ADDI    = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B,
    OP_ANDI    = 6'h0C, OP_ORI    = 6'h0D, OP_XORI  = 6'h0E, OP_LUI   = 6'h0F,
    OP_LB      = 6'h20, OP_LH     = 6'h21, OP_LWL   = 6'h22, OP_LW    = 6'h23,
    OP_LBU     = 6'h24, OP_LHU    = 6'h25, OP_LWR   = 6'h26, OP_SB    = 6'h28,
    OP_SH      = 6'h29, OP_SW     = 6'h2B
  } op_t;

  typedef enum logic [5:0] {
    F_SLL  = 6'h00, F_SRL   = 6'h02, F_SRA  = 6'h03, F_SLLV  = 6'h04,
    F_SRLV = 6'h06, F_SRAV  = 6'h07, F_JR   = 6'h08, F_JALR  = 6'h09,
    F_MFHI = 6'h10, F_MTHI  = 6'h11, F_MFLO = 6'h12, F_MTLO  = 6'h13,
    F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV  = 6'h1A, F_DIVU  = 6'h1B,
    F_ADD  = 6'h20, F_ADDU  = 6'h21, F_SUB  = 6'h22, F_SUBU  = 6'h23,
    F_AND  = 6'h24, F_OR    = 6'h25, F_XOR  = 6'h26, F_NOR   = 6'h27,
    F_SLT  = 6'h2A, F_SLTU  = 6'h2B
  } funct_t;

  typedef enum logic [4:0] {
    RT_BLTZ = 5'h00, RT_BGEZ = 5'h01, RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11
  } regimm_rt_t;

  // Code 0 and codes above M_SW are deliberately left unassigned (unsupported).
  typedef enum logic [5:0] {
    M_NONE = 6'd0,
    M_SLL, M_SRL, M_SRA, M_SLLV, M_SRLV, M_SRAV, M_JR, M_JALR,
    M_MFHI, M_MTHI, M_MFLO, M_MTLO, M_MULT, M_MULTU, M_DIV, M_DIVU,
    M_ADD, M_ADDU, M_SUB, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU,
    M_BLTZ, M_BGEZ, M_BLTZAL, M_BGEZAL,
    M_J, M_JAL,
    M_BEQ, M_BNE, M_BLEZ, M_BGTZ,
    M_ADDI, M_ADDIU, M_SLTI, M_SLTIU, M_ANDI, M_ORI, M_XORI, M_LUI,
    M_LB, M_LH, M_LWL, M_LW, M_LBU, M_LHU, M_LWR, M_SB, M_SH, M_SW
  } mnem_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input funct_t f);
    return {OP_SPECIAL, rs, rt, rd, sh, f};
  endfunction

  function automatic logic [31:0] i_word(input op_t op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_word(input op_t op, input logic [25:0] target);
    return {op, target};
  endfunction

endpackage

// File: rtl/mips_cpu_instr_encoder_pack.sv
// Combinational packer: mnemonic + fields -> {valid, 32-bit MIPS I word}.
// Fields a given format does not use are forced to zero here.
module mips_instr_pack
  import mips_cpu_instr_encoder_pkg::*;
(
  input  logic [5:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [25:0] imm,
  output logic        valid,
  output logic [31:0] word
);

  logic [15:0] imm16;
  logic [4:0]  jalr_rd;

  assign imm16   = imm[15:0];
  // JALR with no explicit link register links through $ra.
  assign jalr_rd = (rd == 5'd0) ? 5'd31 : rd;

  // Select the instruction format and forced-zero fields for each mnemonic.
  always_comb begin
    valid = 1'b1;
    word  = 32'd0;
    case (mnem)
      M_SLL:    word = r_word(5'd0, rt, rd, shamt, F_SLL);
      M_SRL:    word = r_word(5'd0, rt, rd, shamt, F_SRL);
      M_SRA:    word = r_word(5'd0, rt, rd, shamt, F_SRA);
      M_SLLV:   word = r_word(rs, rt, rd, 5'd0, F_SLLV);
      M_SRLV:   word = r_word(rs, rt, rd, 5'd0, F_SRLV);
      M_SRAV:   word = r_word(rs, rt, rd, 5'd0, F_SRAV);
      M_JR:     word = r_word(rs, 5'd0, 5'd0, 5'd0, F_JR);
      M_JALR:   word = r_word(rs, 5'd0, jalr_rd, 5'd0, F_JALR);
      M_MFHI:   word = r_word(5'd0, 5'd0, rd, 5'd0, F_MFHI);
      M_MFLO:   word = r_word(5'd0, 5'd0, rd, 5'd0, F_MFLO);
      M_MTHI:   word = r_word(rs, 5'd0, 5'd0, 5'd0, F_MTHI);
      M_MTLO:   word = r_word(rs, 5'd0, 5'd0, 5'd0, F_MTLO);
      M_MULT:   word = r_word(rs, rt, 5'd0, 5'd0, F_MULT);
      M_MULTU:  word = r_word(rs, rt, 5'd0, 5'd0, F_MULTU);
      M_DIV:    word = r_word(rs, rt, 5'd0, 5'd0, F_DIV);
      M_DIVU:   word = r_word(rs, rt, 5'd0, 5'd0, F_DIVU);
      M_ADD:    word = r_word(rs, rt, rd, 5'd0, F_ADD);
      M_ADDU:   word = r_word(rs, rt, rd, 5'd0, F_ADDU);
      M_SUB:    word = r_word(rs, rt, rd, 5'd0, F_SUB);
      M_SUBU:   word = r_word(rs, rt, rd, 5'd0, F_SUBU);
      M_AND:    word = r_word(rs, rt, rd, 5'd0, F_AND);
      M_OR:     word = r_word(rs, rt, rd, 5'd0, F_OR);
      M_XOR:    word = r_word(rs, rt, rd, 5'd0, F_XOR);
      M_NOR:    word = r_word(rs, rt, rd, 5'd0, F_NOR);
      M_SLT:    word = r_word(rs, rt, rd, 5'd0, F_SLT);
      M_SLTU:   word = r_word(rs, rt, rd, 5'd0, F_SLTU);
      M_BLTZ:   word = i_word(OP_REGIMM, rs, RT_BLTZ, imm16);
      M_BGEZ:   word = i_word(OP_REGIMM, rs, RT_BGEZ, imm16);
      M_BLTZAL: word = i_word(OP_REGIMM, rs, RT_BLTZAL, imm16);
      M_BGEZAL: word = i_word(OP_REGIMM, rs, RT_BGEZAL, imm16);
      M_J:      word = j_word(OP_J, imm);
      M_JAL:    word = j_word(OP_JAL, imm);
      M_BEQ:    word = i_word(OP_BEQ, rs, rt, imm16);
      M_BNE:    word = i_word(OP_BNE, rs, rt, imm16);
      M_BLEZ:   word = i_word(OP_BLEZ, rs, 5'd0, imm16);
      M_BGTZ:   word = i_word(OP_BGTZ, rs, 5'd0, imm16);
      M_ADDI:   word = i_word(OP_ADDI, rs, rt, imm16);
      M_ADDIU:  word = i_word(OP_ADDIU, rs, rt, imm16);
      M_SLTI:   word = i_word(OP_SLTI, rs, rt, imm16);
      M_SLTIU:  word = i_word(OP_SLTIU, rs, rt, imm16);
      M_ANDI:   word = i_word(OP_ANDI, rs, rt, imm16);
      M_ORI:    word = i_word(OP_ORI, rs, rt, imm16);
      M_XORI:   word = i_word(OP_XORI, rs, rt, imm16);
      M_LUI:    word = i_word(OP_LUI, 5'd0, rt, imm16);
      M_LB:     word = i_word(OP_LB, rs, rt, imm16);
      M_LH:     word = i_word(OP_LH, rs, rt, imm16);
      M_LWL:    word = i_word(OP_LWL, rs, rt, imm16);
      M_LW:     word = i_word(OP_LW, rs, rt, imm16);
      M_LBU:    word = i_word(OP_LBU, rs, rt, imm16);
      M_LHU:    word = i_word(OP_LHU, rs, rt, imm16);
      M_LWR:    word = i_word(OP_LWR, rs, rt, imm16);
      M_SB:     word = i_word(OP_SB, rs, rt, imm16);
      M_SH:     word = i_word(OP_SH, rs, rt, imm16);
      M_SW:     word = i_word(OP_SW, rs, rt, imm16);
      default:  valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_cpu_instr_encoder.sv
// Instruction encoder / program loader: accepts symbolic instructions,
// packs them and writes them to consecutive words starting at BASE_ADDR.
module mips_cpu_instr_encoder
  import mips_cpu_instr_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int          DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_mnem,
  input  logic [4:0]  req_rs,
  input  logic [4:0]  req_rt,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_shamt,
  input  logic [25:0] req_imm,
  output logic [31:0] mem_address,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  input  logic        mem_waitrequest,
  output logic [15:0] count,
  output logic        full,
  output logic        error
);

  localparam logic [15:0] DEPTH_W = 16'(DEPTH_WORDS);

  state_t      state;
  state_t      state_nxt;
  logic        pack_valid;
  logic [31:0] pack_word;
  logic        accept;
  logic        done;
  logic [15:0] count_inc;

  mips_instr_pack u_pack (
    .mnem  (req_mnem),
    .rs    (req_rs),
    .rt    (req_rt),
    .rd    (req_rd),
    .shamt (req_shamt),
    .imm   (req_imm),
    .valid (pack_valid),
    .word  (pack_word)
  );

  assign accept    = req_valid && req_ready;
  assign done      = (state == S_WRITE) && !mem_waitrequest;
  assign count_inc = count + 16'd1;

  // State register; reset abandons any write in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state: accept supported requests, finish writes, stop when full.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept && pack_valid) state_nxt = S_WRITE;
      S_WRITE: if (!mem_waitrequest) state_nxt = (count_inc == DEPTH_W) ? S_FULL : S_IDLE;
      S_FULL:  state_nxt = S_FULL;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state only, never from req_valid.
  always_comb begin
    req_ready      = (state == S_IDLE) && !full;
    mem_write      = (state == S_WRITE);
    mem_byteenable = (state == S_WRITE) ? 4'b1111 : 4'b0000;
  end

  // Bus word/address capture, word counter and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_address   <= BASE_ADDR;
      mem_writedata <= 32'd0;
      count         <= 16'd0;
      full          <= 1'b0;
      error         <= 1'b0;
    end else begin
      if (accept && pack_valid) begin
        mem_address   <= BASE_ADDR + {14'd0, count, 2'b00};
        mem_writedata <= pack_word;
      end
      if (accept && !pack_valid) error <= 1'b1;
      if (done) begin
        count <= count_inc;
        full  <= (count_inc == DEPTH_W);
      end
    end
  end

endmodule
